// File: rtl/l1v_yanitlayici_if.sv
// l1v_yanitlayici_if: core-side L1V request/response and memory-side bus signals of the L1 data cache
interface l1v_yanitlayici_if #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int SOZCUK_GENISLIGI = 32,
  parameter int MASKE_GENISLIGI_BIT = 4
);
  logic [ADRES_GENISLIGI-1:0] l1v_adres_i;
  logic l1v_gecerli_i;
  logic l1v_yaz_i;
  logic [MASKE_GENISLIGI_BIT-1:0] l1v_maske_i;
  logic [SOZCUK_GENISLIGI-1:0] l1v_veri_i;
  logic [SOZCUK_GENISLIGI-1:0] l1v_veri_o;
  logic l1v_hazir_o;
  logic bel_istek_o;
  logic bel_yaz_o;
  logic [ADRES_GENISLIGI-1:0] bel_adres_o;
  logic [MASKE_GENISLIGI_BIT-1:0] bel_maske_o;
  logic [SOZCUK_GENISLIGI-1:0] bel_veri_o;
  logic bel_kabul_i;
  logic bel_yanit_gecerli_i;
  logic [SOZCUK_GENISLIGI-1:0] bel_veri_i;
  modport slave (
    input l1v_adres_i, l1v_gecerli_i, l1v_yaz_i, l1v_maske_i, l1v_veri_i,
    input bel_kabul_i, bel_yanit_gecerli_i, bel_veri_i,
    output l1v_veri_o, l1v_hazir_o, bel_istek_o, bel_yaz_o, bel_adres_o, bel_maske_o, bel_veri_o
  );
  modport master (
    output l1v_adres_i, l1v_gecerli_i, l1v_yaz_i, l1v_maske_i, l1v_veri_i,
    output bel_kabul_i, bel_yanit_gecerli_i, bel_veri_i,
    input l1v_veri_o, l1v_hazir_o, bel_istek_o, bel_yaz_o, bel_adres_o, bel_maske_o, bel_veri_o
  );
endinterface

// File: rtl/l1v_yanitlayici.sv
// l1v_yanitlayici: direct-mapped write-through no-write-allocate L1 data cache answering the core's L1V port
module l1v_yanitlayici #(
  parameter int ADRES_GENISLIGI = 32,
  parameter int SOZCUK_GENISLIGI = 32,
  parameter int MASKE_GENISLIGI_BIT = 4,
  parameter int SATIR_SAYISI = 64,
  parameter int SATIR_SOZCUK = 4
) (
  input logic clk_i,
  input logic rst_i,
  l1v_yanitlayici_if.slave bus
);
  localparam int OW = $clog2(SATIR_SOZCUK);
  localparam int IW = $clog2(SATIR_SAYISI);
  localparam int TW = ADRES_GENISLIGI - 2 - OW - IW;
  typedef enum logic [1:0] {BOS, YAZ, DOLDUR_ISTEK, DOLDUR_BEKLE} durum_t;
  durum_t r_durum;
  logic [SATIR_SAYISI-1:0] r_gecerli;
  logic [TW-1:0] r_etiket [SATIR_SAYISI];
  logic [SOZCUK_GENISLIGI-1:0] r_veri [SATIR_SAYISI*SATIR_SOZCUK];
  logic [OW-1:0] r_sayac;
  logic [ADRES_GENISLIGI-1:0] r_adres;
  logic [MASKE_GENISLIGI_BIT-1:0] r_maske;
  logic [SOZCUK_GENISLIGI-1:0] r_yveri;
  logic r_isabet;
  logic [SOZCUK_GENISLIGI-1:0] w_kelime, w_birlesik;
  logic w_isabet, w_bos, w_yazma, w_istek, w_son, w_yukle_isabet;
  logic [IW-1:0] w_idx, w_ridx;
  logic [OW-1:0] w_ofs, w_rofs;
  logic [TW-1:0] w_tag, w_rtag;
  assign w_ofs = bus.l1v_adres_i[2 +: OW];
  assign w_idx = bus.l1v_adres_i[2+OW +: IW];
  assign w_tag = bus.l1v_adres_i[ADRES_GENISLIGI-1 -: TW];
  assign w_rofs = r_adres[2 +: OW];
  assign w_ridx = r_adres[2+OW +: IW];
  assign w_rtag = r_adres[ADRES_GENISLIGI-1 -: TW];
  assign w_isabet = r_gecerli[w_idx] && r_etiket[w_idx] == w_tag;
  assign w_kelime = r_veri[{w_idx, w_ofs}];
  assign w_bos = r_durum == BOS;
  assign w_yazma = r_durum == YAZ;
  assign w_istek = !rst_i && (w_yazma || r_durum == DOLDUR_ISTEK);
  assign w_son = r_sayac == OW'(SATIR_SOZCUK - 1);
  assign w_yukle_isabet = !rst_i && w_bos && bus.l1v_gecerli_i && !bus.l1v_yaz_i && w_isabet;
  // store-hit merge: only the enabled bytes of the latched store overwrite the cached word
  always_comb begin
    w_birlesik = r_veri[{w_ridx, w_rofs}];
    for (int b = 0; b < MASKE_GENISLIGI_BIT; b++)
      if (r_maske[b]) w_birlesik[8*b +: 8] = r_yveri[8*b +: 8];
  end
  assign bus.l1v_hazir_o = !rst_i && (w_bos ? (!bus.l1v_gecerli_i || (bus.l1v_yaz_i ? bus.l1v_maske_i == '0 : w_isabet))
                                            : w_yazma && bus.bel_kabul_i);
  assign bus.l1v_veri_o = w_yukle_isabet ? w_kelime : '0;
  assign bus.bel_istek_o = w_istek;
  assign bus.bel_yaz_o = w_istek && w_yazma;
  assign bus.bel_adres_o = !w_istek ? '0 : w_yazma ? r_adres : {r_adres[ADRES_GENISLIGI-1:2+OW], r_sayac, 2'b00};
  assign bus.bel_maske_o = !w_istek ? '0 : w_yazma ? r_maske : '1;
  assign bus.bel_veri_o = (w_istek && w_yazma) ? r_yveri : '0;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOS;
      r_gecerli <= '0;
      r_sayac <= '0;
    end else begin
      case (r_durum)
        BOS: if (bus.l1v_gecerli_i) begin
          r_adres <= bus.l1v_adres_i;
          r_maske <= bus.l1v_maske_i;
          r_yveri <= bus.l1v_veri_i;
          r_isabet <= w_isabet;
          if (!bus.l1v_yaz_i && !w_isabet) begin
            r_gecerli[w_idx] <= 1'b0;
            r_sayac <= '0;
            r_durum <= DOLDUR_ISTEK;
          end else if (bus.l1v_yaz_i && bus.l1v_maske_i != '0) r_durum <= YAZ;
        end
        YAZ: if (bus.bel_kabul_i) r_durum <= BOS;
        DOLDUR_ISTEK: if (bus.bel_kabul_i) r_durum <= DOLDUR_BEKLE;
        DOLDUR_BEKLE: if (bus.bel_yanit_gecerli_i) begin
          if (w_son) begin
            r_gecerli[w_ridx] <= 1'b1;
            r_durum <= BOS;
          end else begin
            r_sayac <= r_sayac + 1'b1;
            r_durum <= DOLDUR_ISTEK;
          end
        end
        default: r_durum <= BOS;
      endcase
    end
  end
  // tag and data arrays carry no reset; the valid flops alone decide whether a line hits
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      if (w_yazma && bus.bel_kabul_i && r_isabet) r_veri[{w_ridx, w_rofs}] <= w_birlesik;
      if (r_durum == DOLDUR_BEKLE && bus.bel_yanit_gecerli_i) begin
        r_veri[{w_ridx, r_sayac}] <= bus.bel_veri_i;
        if (w_son) r_etiket[w_ridx] <= w_rtag;
      end
    end
  end
endmodule

// File: tb/tb_l1v_yanitlayici.sv
// tb_l1v_yanitlayici: randomized bench for the L1V cache with a transaction-level cache/memory model
module tb_l1v_yanitlayici;
  localparam int SS = 4;
  typedef struct {
    bit yaz;
    logic [31:0] adres;
    logic [3:0] maske;
    logic [31:0] veri;
    int w;
    int r;
  } islem_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  l1v_yanitlayici_if bus ();
  l1v_yanitlayici dut (.clk_i(clk), .rst_i(rst), .bus(bus));
  islem_t kayit[$];
  int unsigned mem[int unsigned];
  int checks = 0, errors = 0;
  bit agent_on = 1'b0;
  int fix_w = -1, fix_r = -1;
  bit mvalid[64];
  int unsigned mtag[64];

  function automatic int unsigned mem_oku(int unsigned a);
    return mem.exists(a) ? mem[a] : (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
  endfunction

  task automatic chk(input string ad, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", ad, act, exp);
    end
  endtask

  // memory agent: accepts after w idle istek cycles, answers reads r cycles after acceptance
  initial begin
    int wleft, wsec, rleft;
    logic [31:0] radr, m;
    wleft = -1; wsec = 0; rleft = 0; radr = '0;
    bus.bel_kabul_i = 1'b0;
    bus.bel_yanit_gecerli_i = 1'b0;
    bus.bel_veri_i = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!agent_on || rst) begin
        wleft = -1;
        rleft = 0;
        if (agent_on) begin
          bus.bel_kabul_i = 1'b0;
          bus.bel_yanit_gecerli_i = 1'b0;
          bus.bel_veri_i = '0;
        end
        continue;
      end
      bus.bel_kabul_i = 1'b0;
      bus.bel_yanit_gecerli_i = 1'b0;
      bus.bel_veri_i = '0;
      if (rleft > 0) begin
        rleft--;
        if (rleft == 0) begin
          bus.bel_yanit_gecerli_i = 1'b1;
          bus.bel_veri_i = mem_oku(radr);
        end
      end else if (bus.bel_istek_o) begin
        if (wleft < 0) begin
          wleft = fix_w >= 0 ? fix_w : int'($urandom_range(0, 2));
          wsec = wleft;
        end
        if (wleft == 0) begin
          islem_t t;
          t.yaz = bus.bel_yaz_o;
          t.adres = bus.bel_adres_o;
          t.maske = bus.bel_maske_o;
          t.veri = bus.bel_veri_o;
          t.w = wsec;
          t.r = t.yaz ? 0 : (fix_r >= 0 ? fix_r : int'($urandom_range(1, 3)));
          kayit.push_back(t);
          bus.bel_kabul_i = 1'b1;
          if (t.yaz) begin
            m = mem_oku(t.adres);
            for (int b = 0; b < 4; b++) if (t.maske[b]) m[8*b +: 8] = t.veri[8*b +: 8];
            mem[t.adres] = m;
          end else begin
            radr = t.adres;
            rleft = t.r;
          end
          wleft = -1;
        end else wleft--;
      end
    end
  end

  // per-cycle output rules
  initial forever begin
    @(negedge clk);
    #2;
    if (rst) begin
      chk("rst_hazir", 32'(bus.l1v_hazir_o), 0);
      chk("rst_istek", 32'(bus.bel_istek_o), 0);
      chk("rst_veri", bus.l1v_veri_o, 0);
    end
    if (!bus.bel_istek_o)
      chk("bel_idle", bus.bel_adres_o | bus.bel_veri_o | {28'b0, bus.bel_maske_o} | {31'b0, bus.bel_yaz_o}, 0);
    if (!(bus.l1v_hazir_o && bus.l1v_gecerli_i && !bus.l1v_yaz_i)) chk("veri_idle", bus.l1v_veri_o, 0);
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.l1v_gecerli_i = 1'b0;
    end
  endtask

  task automatic model_reset();
    foreach (mvalid[i]) mvalid[i] = 1'b0;
  endtask

  task automatic req(input bit yaz, input logic [31:0] a, input logic [3:0] m, input logic [31:0] d,
                     output logic [31:0] got, output int cyc, output int n);
    int k0, idx, exp_cyc;
    int unsigned tg;
    bit hit, to;
    k0 = kayit.size();
    idx = int'((a >> 4) & 32'h3F);
    tg = a >> 10;
    hit = mvalid[idx] && mtag[idx] == tg;
    to = 1'b0;
    @(negedge clk);
    bus.l1v_gecerli_i = 1'b1;
    bus.l1v_yaz_i = yaz;
    bus.l1v_adres_i = a;
    bus.l1v_maske_i = m;
    bus.l1v_veri_i = d;
    cyc = 0;
    forever begin
      #2;
      cyc++;
      if (bus.l1v_hazir_o) break;
      if (cyc > 300) begin
        to = 1'b1;
        break;
      end
      @(negedge clk);
    end
    got = bus.l1v_veri_o;
    n = kayit.size() - k0;
    if (to) begin
      chk("retire_timeout", 32'(to), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
    if (!yaz) begin
      chk("load_data", got, mem_oku(a));
      if (hit) begin
        chk("hit_cycles", cyc, 1);
        chk("hit_tx", n, 0);
      end else begin
        exp_cyc = 2;
        chk("miss_tx", n, SS);
        for (int i = 0; i < n && i < SS; i++) begin
          islem_t t;
          t = kayit[k0+i];
          chk("refill_adres", t.adres, (a & ~32'hF) + 32'(4 * i));
          chk("refill_kind", {31'b0, t.yaz} | {28'b0, ~t.maske}, 0);
          exp_cyc += t.w + 1 + t.r;
        end
        chk("miss_cycles", cyc, exp_cyc);
        mvalid[idx] = 1'b1;
        mtag[idx] = tg;
      end
    end else if (m == 4'b0) begin
      chk("nop_cycles", cyc, 1);
      chk("nop_tx", n, 0);
    end else begin
      chk("store_tx", n, 1);
      if (n >= 1) begin
        chk("store_yaz", 32'(kayit[k0].yaz), 1);
        chk("store_adres", kayit[k0].adres, a);
        chk("store_maske", 32'(kayit[k0].maske), 32'(m));
        chk("store_veri", kayit[k0].veri, d);
        chk("store_cycles", cyc, kayit[k0].w + 2);
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    int cyc, n, k0;
    int idxs[4];
    int unsigned tags[4];
    idxs = '{0, 1, 16, 63};
    tags = '{0, 1, 2, 32'h3FFFFF};
    bus.l1v_gecerli_i = 1'b0;
    bus.l1v_yaz_i = 1'b0;
    bus.l1v_adres_i = '0;
    bus.l1v_maske_i = '0;
    bus.l1v_veri_i = '0;
    for (int i = 0; i < 4; i++) mem[32'h100 + 32'(4 * i)] = 32'hA0 + 32'(i);
    model_reset();
    agent_on = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    idle(1);
    fix_w = 0;
    fix_r = 2;
    // miss cycle + 4*(1+2) refill cycles + hit cycle
    req(0, 32'h100, 4'h0, 0, got, cyc, n);
    chk("first_miss_cycles", cyc, 14);
    chk("first_miss_data", got, 32'hA0);
    chk("first_miss_reads", n, 4);
    req(0, 32'h104, 4'h0, 0, got, cyc, n);
    chk("hit_104_data", got, 32'hA1);
    chk("hit_104_tx", n, 0);
    req(1, 32'h108, 4'b0011, 32'hAABBCCDD, got, cyc, n);
    chk("store_108_cycles", cyc, 2);
    req(0, 32'h108, 4'h0, 0, got, cyc, n);
    chk("merged_108", got, 32'h0000CCDD);
    chk("merged_108_tx", n, 0);
    req(1, 32'h2000, 4'hF, 32'h12345678, got, cyc, n);
    chk("miss_store_tx", n, 1);
    req(0, 32'h2000, 4'h0, 0, got, cyc, n);
    chk("after_miss_store_reads", n, 4);
    chk("after_miss_store_data", got, 32'h12345678);
    req(0, 32'h100, 4'h0, 0, got, cyc, n);
    chk("alias_pre_hit", n, 0);
    req(0, 32'h500, 4'h0, 0, got, cyc, n);
    chk("alias_fill", n, 4);
    req(0, 32'h100, 4'h0, 0, got, cyc, n);
    chk("alias_refetch", n, 4);
    chk("alias_refetch_data", got, 32'hA0);
    // reset while waiting for a refill response, then a stray late response
    fix_r = 3;
    idle(1);
    k0 = kayit.size();
    @(negedge clk);
    bus.l1v_gecerli_i = 1'b1;
    bus.l1v_yaz_i = 1'b0;
    bus.l1v_adres_i = 32'h3000;
    for (int i = 0; i < 50 && kayit.size() == k0; i++) @(negedge clk);
    chk("rst_test_read_issued", kayit.size(), k0 + 1);
    agent_on = 1'b0;
    rst = 1'b1;
    bus.l1v_gecerli_i = 1'b0;
    bus.bel_kabul_i = 1'b0;
    bus.bel_yanit_gecerli_i = 1'b0;
    #2;
    chk("rst_mid_istek", 32'(bus.bel_istek_o), 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bus.bel_yanit_gecerli_i = 1'b1;
    bus.bel_veri_i = 32'hDEADBEEF;
    @(negedge clk);
    bus.bel_yanit_gecerli_i = 1'b0;
    bus.bel_veri_i = '0;
    agent_on = 1'b1;
    model_reset();
    #2;
    chk("late_resp_idle", 32'(bus.bel_istek_o), 0);
    req(0, 32'h100, 4'h0, 0, got, cyc, n);
    chk("post_rst_reads", n, 4);
    chk("post_rst_data", got, 32'hA0);
    fix_w = -1;
    fix_r = -1;
    for (int i = 0; i < 300; i++) begin
      logic [31:0] a;
      a = (tags[$urandom_range(0, 3)] << 10) | (32'(idxs[$urandom_range(0, 3)]) << 4) | (32'($urandom_range(0, 3)) << 2);
      req($urandom_range(0, 9) < 4, a, 4'($urandom_range(0, 15)), $urandom, got, cyc, n);
    end
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
